down_counter: RTL and testbench
===============================

DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 Parameter PRESCALE, default 4: number of enabled Slt=1 cycles per Output1 decrement; legal range 1..256.
REQ-002 Parameter AUTO_RELOAD, default 0: 1 means a channel reloads its last loaded value when decremented at zero; 0 means it saturates at zero.
REQ-003 Port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port Load, input, 1 bit: load Din into the channel selected by Slt.
REQ-006 Port Slt, input, 1 bit: channel select; 0 selects channel 0, 1 selects channel 1.
REQ-007 Port En, input, 1 bit: count enable for the selected channel.
REQ-008 Port Din, input, 64 bits: load value.
REQ-009 Port Output0, output, 64 bits: channel 0 count, registered.
REQ-010 Port Output1, output, 64 bits: channel 1 count, registered.
REQ-011 Port Zero0 and Zero1, output, 1 bit each: combinational flags, (Output0==0) and (Output1==0).
REQ-012 Port Done0 and Done1, output, 1 bit each: registered one-cycle terminal-count pulses.

Function
REQ-013 The block SHALL update only the channel selected by Slt at each edge; the unselected channel, its prescaler and its reload register SHALL hold.
REQ-014 Load=1 SHALL have priority over En at the same edge.
REQ-015 Load=1 SHALL write Din into the selected Output and into that channel's 64-bit reload register.
REQ-016 Load=1 with Slt=1 SHALL also clear the channel 1 prescaler.
REQ-017 Channel 0 (Load=0, En=1, Slt=0) SHALL decrement Output0 by 1 per edge when Output0 is nonzero; latency is one edge.
REQ-018 Channel 1 (Load=0, En=1, Slt=1) SHALL advance the prescaler pre1 (width clog2(PRESCALE), minimum 1 bit) by 1 per edge.
REQ-019 When pre1 equals PRESCALE-1, pre1 SHALL return to 0 and Output1 SHALL take a decrement event at that same edge.
REQ-020 The first decrement after a load or reset SHALL occur on the PRESCALE-th enabled Slt=1 edge.
REQ-021 With PRESCALE=1, Output1 SHALL decrement on every enabled Slt=1 edge.
REQ-022 A decrement event at nonzero value SHALL subtract 1.
REQ-023 A decrement event at zero with AUTO_RELOAD=0 SHALL leave the Output at 0; the count SHALL never wrap to all-ones.
REQ-024 A decrement event at zero with AUTO_RELOAD=1 SHALL load the reload register value; if that value is 0, the Output SHALL stay 0.
REQ-025 DoneN SHALL be 1 for exactly the one cycle following an edge at which OutputN went from 1 to 0 by decrement.
REQ-026 Loading 0, reset and auto-reload SHALL never assert DoneN.
REQ-027 En=0 with Load=0 SHALL hold all state, and Done0 and Done1 SHALL be 0 in the following cycle.
REQ-028 Slt changing mid-prescale SHALL freeze pre1 at its current value; counting resumes from that value when Slt returns to 1.

Reset
REQ-029 Reset=0 SHALL, immediately and independent of Clk, force to zero: Output0, Output1, both reload registers, pre1, Done0 and Done1.
REQ-030 Zero0 and Zero1 SHALL read 1 while in reset.
REQ-031 Reset asserted mid-count SHALL abandon the count with no Done pulse.
REQ-032 The first active edge after Reset releases SHALL be processed normally; Reset deassertion is synchronous to Clk at integration level.

Verification
REQ-033 Directed test, channel 0 countdown:
- Stimulus: reset; Load=1, Slt=0, Din=3; then En=1, Slt=0 for 4 edges.
- Required response: Output0 goes 3,2,1,0,0; Done0=1 for one cycle only; Zero0=1 from the third edge onward.
REQ-034 Directed test, channel 1 prescale (PRESCALE=4):
- Stimulus: Load Din=2 into channel 1; En=1, Slt=1 for 9 edges.
- Required response: Output1=1 after edge 4, 0 after edge 8, 0 after edge 9; Done1 pulses once, after edge 8.
REQ-035 Directed test, auto-reload (AUTO_RELOAD=1):
- Stimulus: load 2 into channel 0; run 4 enabled edges.
- Required response: Output0 goes 1,0,2,1; Done0 pulses once, after edge 2.
REQ-036 Directed test, Load priority and channel isolation:
- Stimulus: Output0=5 counting; at one edge set Load=1, En=1, Slt=0, Din=9; then Slt=1 with En=1 for 3 edges.
- Required response: Output0=9 with no decrement at the load edge; Output0 then holds at 9 while Slt=1.
REQ-037 Directed test, asynchronous reset mid-operation:
- Stimulus: assert Reset=0 between clock edges while Output1=7 and pre1=2.
- Required response: Output1=0, pre1=0, Done1=0 before the next edge.
- After release, load 1 and run 4 enabled Slt=1 edges: Output1 reaches 0 on edge 4.

Source files
------------

// File: rtl/down_counter_if.sv
// Bus bundle for down_counter: load/select/enable controls in, both channel
// counts and their zero/terminal-count flags out.
//   master : drives Load, Slt, En, Din; observes counts and flags
//   slave  : the counter itself
interface down_counter_if;
  logic        Load;
  logic        Slt;
  logic        En;
  logic [63:0] Din;
  logic [63:0] Output0;
  logic [63:0] Output1;
  logic        Zero0;
  logic        Zero1;
  logic        Done0;
  logic        Done1;

  modport master (
    output Load, Slt, En, Din,
    input  Output0, Output1, Zero0, Zero1, Done0, Done1
  );

  modport slave (
    input  Load, Slt, En, Din,
    output Output0, Output1, Zero0, Zero1, Done0, Done1
  );
endinterface

// File: rtl/down_counter.sv
// Two-channel 64-bit down counter.
//   Channel 0 decrements once per enabled edge; channel 1 decrements once per
//   PRESCALE enabled edges. Only the channel chosen by Slt is touched at an
//   edge; Load beats En. At zero a channel saturates, or with AUTO_RELOAD
//   reloads the value last loaded into it.
// Ports:
//   Clk            rising-edge clock
//   Reset          asynchronous active-low reset
//   bus.Load/Slt/En/Din      control and load value
//   bus.Output0/Output1      registered channel counts
//   bus.Zero0/Zero1          combinational count==0 flags
//   bus.Done0/Done1          registered one-cycle 1->0 decrement pulses
module down_counter #(
  parameter int unsigned PRESCALE    = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic           Clk,
  input  logic           Reset,
  down_counter_if.slave  bus
);

  localparam int unsigned CNT_W = 64;
  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [CNT_W-1:0] out0_q, out0_d, out1_q, out1_d;
  logic [CNT_W-1:0] rel0_q, rel0_d, rel1_q, rel1_d;
  logic [PRE_W-1:0] pre1_q, pre1_d;
  logic             done0_q, done0_d, done1_q, done1_d;

  // Value after a decrement event: subtract, saturate at zero, or reload.
  function automatic logic [CNT_W-1:0] dec_val(input logic [CNT_W-1:0] cur,
                                               input logic [CNT_W-1:0] rel);
    if (cur != '0)
      return cur - CNT_W'(1);
    else if (AUTO_RELOAD)
      return rel;
    else
      return '0;
  endfunction

  // Next-state logic for both channels.
  always_comb begin
    out0_d  = out0_q;
    out1_d  = out1_q;
    rel0_d  = rel0_q;
    rel1_d  = rel1_q;
    pre1_d  = pre1_q;
    done0_d = 1'b0;
    done1_d = 1'b0;

    if (bus.Load) begin
      if (!bus.Slt) begin
        out0_d = bus.Din;
        rel0_d = bus.Din;
      end else begin
        out1_d = bus.Din;
        rel1_d = bus.Din;
        pre1_d = '0;
      end
    end else if (bus.En) begin
      if (!bus.Slt) begin
        out0_d  = dec_val(out0_q, rel0_q);
        done0_d = (out0_q == CNT_W'(1));
      end else if (pre1_q == PRE_LAST) begin
        // Last prescale step: wrap prescaler and take the decrement event.
        pre1_d  = '0;
        out1_d  = dec_val(out1_q, rel1_q);
        done1_d = (out1_q == CNT_W'(1));
      end else begin
        pre1_d = pre1_q + PRE_W'(1);
      end
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      out0_q  <= '0;
      out1_q  <= '0;
      rel0_q  <= '0;
      rel1_q  <= '0;
      pre1_q  <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      rel0_q  <= rel0_d;
      rel1_q  <= rel1_d;
      pre1_q  <= pre1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign bus.Output0 = out0_q;
  assign bus.Output1 = out1_q;
  assign bus.Done0   = done0_q;
  assign bus.Done1   = done1_q;
  assign bus.Zero0   = (out0_q == '0);
  assign bus.Zero1   = (out1_q == '0);

endmodule

// File: tb/tb_down_counter.sv
// Bench for down_counter: two instances share one stimulus stream.
//   A: PRESCALE=4, AUTO_RELOAD=0     B: PRESCALE=1, AUTO_RELOAD=1
module tb_down_counter;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic        Load  = 1'b0;
  logic        Slt   = 1'b0;
  logic        En    = 1'b0;
  logic [63:0] Din   = '0;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  down_counter_if ifa ();
  down_counter_if ifb ();

  assign ifa.Load = Load;
  assign ifa.Slt  = Slt;
  assign ifa.En   = En;
  assign ifa.Din  = Din;
  assign ifb.Load = Load;
  assign ifb.Slt  = Slt;
  assign ifb.En   = En;
  assign ifb.Din  = Din;

  down_counter #(.PRESCALE(4), .AUTO_RELOAD(1'b0)) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(ifa.slave));
  down_counter #(.PRESCALE(1), .AUTO_RELOAD(1'b1)) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(ifb.slave));

  // DUT outputs gathered by [instance][channel]
  logic [63:0] d_o [2][2];
  logic        d_z [2][2];
  logic        d_d [2][2];
  assign d_o[0][0] = ifa.Output0;  assign d_o[0][1] = ifa.Output1;
  assign d_o[1][0] = ifb.Output0;  assign d_o[1][1] = ifb.Output1;
  assign d_z[0][0] = ifa.Zero0;    assign d_z[0][1] = ifa.Zero1;
  assign d_z[1][0] = ifb.Zero0;    assign d_z[1][1] = ifb.Zero1;
  assign d_d[0][0] = ifa.Done0;    assign d_d[0][1] = ifa.Done1;
  assign d_d[1][0] = ifb.Done0;    assign d_d[1][1] = ifb.Done1;

  function automatic int ps_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  function automatic bit ar_of(input int i);
    return (i == 0) ? 1'b0 : 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Reference model: per channel count, reload value, and for channel 1 the
  // number of enabled Slt=1 edges seen since the last load/reset.
  logic [63:0] m_o  [2][2];
  logic [63:0] m_r  [2][2];
  logic        m_d  [2][2];
  int          m_ph [2];

  task automatic dec_ev(input int i, input int c);
    if (m_o[i][c] == 64'd1) m_d[i][c] = 1'b1;
    if (m_o[i][c] != 64'd0) m_o[i][c] = m_o[i][c] - 64'd1;
    else if (ar_of(i))      m_o[i][c] = m_r[i][c];
  endtask

  always @(posedge Clk or negedge Reset) begin
    for (int i = 0; i < 2; i++) begin
      m_d[i][0] = 1'b0;
      m_d[i][1] = 1'b0;
      if (!Reset) begin
        for (int c = 0; c < 2; c++) begin
          m_o[i][c] = '0;
          m_r[i][c] = '0;
        end
        m_ph[i] = 0;
      end else if (Load) begin
        m_o[i][Slt] = Din;
        m_r[i][Slt] = Din;
        if (Slt) m_ph[i] = 0;
      end else if (En) begin
        if (!Slt) dec_ev(i, 0);
        else begin
          m_ph[i] = m_ph[i] + 1;
          if (m_ph[i] == ps_of(i)) begin
            m_ph[i] = 0;
            dec_ev(i, 1);
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model while out of reset.
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      for (int i = 0; i < 2; i++) begin
        for (int c = 0; c < 2; c++) begin
          chk($sformatf("cmp_out_i%0d_c%0d", i, c), d_o[i][c], m_o[i][c]);
          chk($sformatf("cmp_zero_i%0d_c%0d", i, c), 64'(d_z[i][c]),
              64'(m_o[i][c] == 64'd0));
          chk($sformatf("cmp_done_i%0d_c%0d", i, c), 64'(d_d[i][c]), 64'(m_d[i][c]));
        end
      end
    end
  end

  task automatic cyc(input logic l, input logic s, input logic e, input logic [63:0] d);
    @(negedge Clk);
    Load = l; Slt = s; En = e; Din = d;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    // reset state
    #1 Reset = 1'b0;
    #1;
    chk("rst_a_o0", ifa.Output0, 64'd0);
    chk("rst_a_o1", ifa.Output1, 64'd0);
    chk("rst_a_z0", 64'(ifa.Zero0), 64'd1);
    chk("rst_b_z1", 64'(ifb.Zero1), 64'd1);
    chk("rst_a_d0", 64'(ifa.Done0), 64'd0);
    #20 Reset = 1'b1;

    // channel 0 countdown from 3
    cyc(1'b1, 1'b0, 1'b0, 64'd3);
    chk("c0_load_a", ifa.Output0, 64'd3);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("c0_e1_a", ifa.Output0, 64'd2);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("c0_e2_a", ifa.Output0, 64'd1);
    chk("c0_e2_z0", 64'(ifa.Zero0), 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("c0_e3_a", ifa.Output0, 64'd0);
    chk("c0_e3_done", 64'(ifa.Done0), 64'd1);
    chk("c0_e3_z0", 64'(ifa.Zero0), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("c0_e4_sat", ifa.Output0, 64'd0);
    chk("c0_e4_done", 64'(ifa.Done0), 64'd0);
    chk("c0_e4_b_reload", ifb.Output0, 64'd3);

    // channel 1 prescale: load 2, 9 enabled edges
    cyc(1'b1, 1'b1, 1'b0, 64'd2);
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 64'd0);
      if (k == 3) chk("p_e3_a", ifa.Output1, 64'd2);
      if (k == 4) chk("p_e4_a", ifa.Output1, 64'd1);
      if (k == 7) chk("p_e7_done", 64'(ifa.Done1), 64'd0);
      if (k == 8) begin
        chk("p_e8_a", ifa.Output1, 64'd0);
        chk("p_e8_done", 64'(ifa.Done1), 64'd1);
      end
      if (k == 9) begin
        chk("p_e9_a", ifa.Output1, 64'd0);
        chk("p_e9_done", 64'(ifa.Done1), 64'd0);
        chk("p_e9_b_ps1", ifb.Output1, 64'd2);
      end
    end

    // auto-reload on channel 0: load 2, 4 enabled edges
    cyc(1'b1, 1'b0, 1'b0, 64'd2);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("ar_e1_b", ifb.Output0, 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("ar_e2_b", ifb.Output0, 64'd0);
    chk("ar_e2_done", 64'(ifb.Done0), 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("ar_e3_b", ifb.Output0, 64'd2);
    chk("ar_e3_done", 64'(ifb.Done0), 64'd0);
    chk("ar_e3_a_sat", ifa.Output0, 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("ar_e4_b", ifb.Output0, 64'd1);

    // load priority over enable, then channel isolation
    cyc(1'b1, 1'b0, 1'b0, 64'd5);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("lp_pre_a", ifa.Output0, 64'd3);
    cyc(1'b1, 1'b0, 1'b1, 64'd9);
    chk("lp_load_a", ifa.Output0, 64'd9);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 64'd0);
    chk("iso_a_o0", ifa.Output0, 64'd9);
    chk("iso_b_o0", ifb.Output0, 64'd9);

    // idle hold and zero-load: no Done
    cyc(1'b1, 1'b0, 1'b0, 64'd1);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    chk("idle_pre_done", 64'(ifa.Done0), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    chk("idle_done", 64'(ifa.Done0), 64'd0);
    chk("idle_hold", ifa.Output0, 64'd0);
    cyc(1'b1, 1'b0, 1'b0, 64'd0);
    chk("load0_done", 64'(ifa.Done0), 64'd0);

    // prescaler frozen while Slt=0
    cyc(1'b1, 1'b1, 1'b0, 64'd7);
    cyc(1'b0, 1'b1, 1'b1, 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 64'd0);
    chk("frz_e3_a", ifa.Output1, 64'd7);
    cyc(1'b0, 1'b1, 1'b1, 64'd0);
    chk("frz_e4_a", ifa.Output1, 64'd6);

    // asynchronous reset mid-count (Output1=7, pre1=2)
    cyc(1'b1, 1'b1, 1'b0, 64'd7);
    cyc(1'b0, 1'b1, 1'b1, 64'd0);
    cyc(1'b0, 1'b1, 1'b1, 64'd0);
    chk("ar_pre_a", ifa.Output1, 64'd7);
    @(negedge Clk);
    En = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("arst_a_o1", ifa.Output1, 64'd0);
    chk("arst_a_d1", 64'(ifa.Done1), 64'd0);
    chk("arst_a_z1", 64'(ifa.Zero1), 64'd1);
    @(negedge Clk);
    #2 Reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 64'd1);
    for (int k = 1; k <= 4; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 64'd0);
      if (k == 3) chk("rel_e3_a", ifa.Output1, 64'd1);
      if (k == 4) begin
        chk("rel_e4_a", ifa.Output1, 64'd0);
        chk("rel_e4_done", 64'(ifa.Done1), 64'd1);
      end
    end

    cyc(1'b0, 1'b0, 1'b0, 64'd0);
    @(negedge Clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
